vend_seq_ctrl: RTL
==================

VEND_SEQ_CTRL -- requirements
Module: vend_seq_ctrl

Interface
REQ-001 SHALL have parameter STOCK_W, default 8, width of stock and vend counters.
REQ-002 SHALL have parameter REV_W, default 16, width of revenue and change totals.
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports slot0_valid / slot1_valid  input  1  coin present at slot 0 / slot 1.
REQ-006 SHALL have ports slot0_coin / slot1_coin  input  2  coin code: 01 = 5 rs, 10 = 10 rs, 00/11 illegal.
REQ-007 SHALL have ports slot0_ready / slot1_ready  output  1  coin accepted this cycle.
REQ-008 SHALL have port core_in  output  2  coin code driven to the vending FSM core; 00 = no coin.
REQ-009 SHALL have port core_out  input  1  bottle-dispense indication from the core.
REQ-010 SHALL have port core_change  input  2  change from the core: 01 = 5 rs, 10 = 10 rs.
REQ-011 SHALL have ports stock_load  input  1  and stock_val  input  STOCK_W: stock reload.
REQ-012 SHALL have outputs sold_out (1), reject (1), vend_count (STOCK_W), revenue (REV_W), change_total (REV_W).

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-014 IDLE: with sold_out=0 and at least one slot valid, SHALL grant exactly one slot, assert its ready for one cycle and go to ISSUE.
REQ-015 Arbitration SHALL be round-robin: when both slots are valid, grant the slot not granted last; after reset, slot 0 has priority.
REQ-016 A handshake completes only on a clock edge with valid=1 and ready=1; ready SHALL be 0 in ISSUE and WAIT.
REQ-017 SHALL latch the granted coin code at the handshake edge.
REQ-018 Illegal code at grant: ready asserted, coin discarded, reject pulses one cycle, pointer updates, FSM stays in IDLE.
REQ-019 ISSUE: core_in SHALL equal the latched code for exactly one cycle; revenue += 5 or 10; next state WAIT.
REQ-020 WAIT: core_in = 00 for exactly one cycle; next state IDLE. Coin-to-coin spacing SHALL therefore be at least 3 cycles.
REQ-021 core_out=1 sampled in ISSUE or WAIT SHALL count one dispense per transaction: vend_count += 1 and stock -= 1.
REQ-022 Stock SHALL saturate at 0; vend_count, revenue and change_total SHALL wrap modulo 2^width.
REQ-023 core_change 01/10 sampled in ISSUE or WAIT SHALL add 5/10 to change_total, at most once per transaction; 00/11 add nothing.
REQ-024 sold_out SHALL be registered and equal (stock == 0); in IDLE with sold_out=1, no grants occur and both readys stay 0.
REQ-025 stock_load SHALL load stock_val in IDLE only and is ignored in ISSUE/WAIT; a load on the same edge as a grant takes effect, and the grant proceeds.
REQ-026 core_out or core_change activity in IDLE SHALL be ignored.

Reset
REQ-027 rst=1 SHALL asynchronously force state IDLE, core_in=00, both readys=0, reject=0, stock=0, sold_out=1, vend_count=0, revenue=0, change_total=0, and RR priority to slot 0.
REQ-028 Reset mid-transaction SHALL abandon the latched coin without issuing it; the first grant after release follows REQ-014.

Verification
REQ-029 Reset, load stock=3, slot0 coin 10 -> slot0_ready one cycle; core_in=10 next cycle then 00; revenue=10.
REQ-030 slot0 and slot1 both valid with 01 continuously -> grants alternate 0,1,0,1; each core_in pulse is one cycle wide with 3-cycle spacing.
REQ-031 Two 10 rs coins issued, core_out=1 in second WAIT -> vend_count=1, stock=2; core_change=01 in the same window -> change_total=5.
REQ-032 stock=1 plus one dispense -> sold_out=1; a subsequent valid coin is never readied; stock_load 5 in IDLE -> sold_out=0 next cycle.
REQ-033 Slot1 coin 11 -> slot1_ready and reject pulse; core_in stays 00; revenue unchanged.
REQ-034 rst asserted during ISSUE -> core_in=00 immediately and all counters 0 without waiting for a clock edge.

Source files
------------

// File: rtl/vend_seq_ctrl.sv
// Coin-slot sequencer in front of a vending FSM core: round-robin slot arbitration,
// one-cycle coin issue with spacing, and stock / vend / revenue / change bookkeeping.
module vend_seq_ctrl #(
  parameter int STOCK_W = 8,
  parameter int REV_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               slot0_valid,
  input  logic [1:0]         slot0_coin,
  output logic               slot0_ready,
  input  logic               slot1_valid,
  input  logic [1:0]         slot1_coin,
  output logic               slot1_ready,
  output logic [1:0]         core_in,
  input  logic               core_out,
  input  logic [1:0]         core_change,
  input  logic               stock_load,
  input  logic [STOCK_W-1:0] stock_val,
  output logic               sold_out,
  output logic               reject,
  output logic [STOCK_W-1:0] vend_count,
  output logic [REV_W-1:0]   revenue,
  output logic [REV_W-1:0]   change_total
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state, state_nxt;
  logic               prio;       // slot that wins when both are valid
  logic [1:0]         code;
  logic [STOCK_W-1:0] stock, stock_nxt;
  logic               dispensed, changed;
  logic               handshake, grant_sel, legal;
  logic [1:0]         grant_code;
  logic               dispense, change_hit;

  always_comb begin
    state_nxt   = state;
    slot0_ready = 1'b0;
    slot1_ready = 1'b0;
    reject      = 1'b0;
    core_in     = 2'b00;
    handshake   = 1'b0;
    grant_sel   = 1'b0;
    grant_code  = 2'b00;
    legal       = 1'b0;
    case (state)
      IDLE: begin
        // sold_out is held high during reset, which also keeps both readys low
        if (!sold_out && (slot0_valid || slot1_valid)) begin
          handshake   = 1'b1;
          grant_sel   = (slot0_valid && slot1_valid) ? prio : slot1_valid;
          grant_code  = grant_sel ? slot1_coin : slot0_coin;
          legal       = (grant_code == 2'b01) || (grant_code == 2'b10);
          slot0_ready = !grant_sel;
          slot1_ready = grant_sel;
          reject      = !legal;
          if (legal) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        core_in   = code;
        state_nxt = WAIT;
      end
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dispense and change are each credited at most once per transaction
  assign dispense   = (state != IDLE) && core_out && !dispensed;
  assign change_hit = (state != IDLE) && !changed &&
                      ((core_change == 2'b01) || (core_change == 2'b10));

  always_comb begin
    stock_nxt = stock;
    if (state == IDLE && stock_load) stock_nxt = stock_val;
    else if (dispense && stock != '0) stock_nxt = stock - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      code         <= 2'b00;
      prio         <= 1'b0;
      stock        <= '0;
      sold_out     <= 1'b1;
      vend_count   <= '0;
      revenue      <= '0;
      change_total <= '0;
      dispensed    <= 1'b0;
      changed      <= 1'b0;
    end else begin
      state    <= state_nxt;
      stock    <= stock_nxt;
      sold_out <= (stock_nxt == '0);
      if (handshake) begin
        prio      <= ~grant_sel;
        code      <= grant_code;
        dispensed <= 1'b0;
        changed   <= 1'b0;
      end
      if (state == ISSUE)
        revenue <= revenue + ((code == 2'b10) ? REV_W'(10) : REV_W'(5));
      if (dispense) begin
        vend_count <= vend_count + 1'b1;
        dispensed  <= 1'b1;
      end
      if (change_hit) begin
        change_total <= change_total + ((core_change == 2'b10) ? REV_W'(10) : REV_W'(5));
        changed      <= 1'b1;
      end
    end
  end
endmodule
